pb_ctrl: RTL and testbench

Pushbutton front end for the ALU lab top level. Synchronizes the four raw pushbuttons to the divided system clock, debounces each one, and turns clean presses into single-cycle load strobes for the A register, B register and output register. It also generates a stretched active-low soft reset for the datapath registers. It sits between the board pins and the `nbit_reg` enables, and runs on the 50 kHz divided clock.

---
 rtl/pb_ctrl.sv | 87 ++++++++
 tb/tb_pb_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pb_ctrl.sv
// Pushbutton front end: synchronizes and debounces four buttons, emits one-cycle
// load strobes and a stretched active-low soft reset for the datapath.
module pb_ctrl #(
   parameter int DEB_CNT = 500,
   parameter int RST_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] pb,
   output logic       en_a,
   output logic       en_b,
   output logic       out_en,
   output logic       rst_out_n,
   output logic [3:0] pb_db
);

   localparam int            CW        = $clog2(DEB_CNT);
   localparam int            RW        = $clog2(RST_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEB_CNT - 1);
   localparam logic [RW-1:0] RCNT_INIT = RW'(RST_LEN);

   logic [3:0]    sync1_q, sync2_q;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [3:0]    db_q, db_d;
   logic [3:0]    rise;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          rst_n_q, rst_n_d;
   logic [2:0]    stb_q, stb_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         rcnt_q  <= RCNT_INIT;
         rst_n_q <= 1'b0;
         stb_q   <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= pb;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         rcnt_q  <= rcnt_d;
         rst_n_q <= rst_n_d;
         stb_q   <= stb_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Per-button debounce: a level change is accepted after DEB_CNT disagreeing samples in a row.
   always_comb begin
      db_d = db_q;
      rise = '0;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i] = ~db_q[i];
               rise[i] = ~db_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // The stretch counter loads on the same edge the soft-reset rise qualifies, so the
   // strobe mask already covers that cycle.
   always_comb begin
      if (rise[3])
         rcnt_d = RCNT_INIT;
      else if (rcnt_q != '0)
         rcnt_d = rcnt_q - RW'(1);
      else
         rcnt_d = rcnt_q;
      rst_n_d = (rcnt_d == '0);
      stb_d   = rise[2:0] & {3{rst_n_d}};
   end

   assign en_a      = stb_q[0];
   assign en_b      = stb_q[1];
   assign out_en    = stb_q[2];
   assign rst_out_n = rst_n_q;
   assign pb_db     = db_q;

endmodule

// File: tb/tb_pb_ctrl.sv
// Directed bench for pb_ctrl: main instance with DEB_CNT=4/RST_LEN=4, second
// instance with DEB_CNT=2/RST_LEN=8 to exercise stretch reload.
module tb_pb_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] pb  = '0;
   logic [3:0] pb2 = '0;
   logic       en_a, en_b, out_en, rst_out_n;
   logic [3:0] pb_db;
   logic       en_a2, en_b2, out_en2, rst_out_n2;
   logic [3:0] pb_db2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pb_ctrl #(.DEB_CNT(4), .RST_LEN(4)) u_dut (
      .clk(clk), .rst(rst), .pb(pb),
      .en_a(en_a), .en_b(en_b), .out_en(out_en),
      .rst_out_n(rst_out_n), .pb_db(pb_db)
   );

   pb_ctrl #(.DEB_CNT(2), .RST_LEN(8)) u_dut2 (
      .clk(clk), .rst(rst), .pb(pb2),
      .en_a(en_a2), .en_b(en_b2), .out_en(out_en2),
      .rst_out_n(rst_out_n2), .pb_db(pb_db2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset both instances and wait until both stretches have expired.
   task automatic do_reset();
      pb  = '0;
      pb2 = '0;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      repeat (9) tick();
   endtask

   task automatic test_reset();
      pb = '0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({en_a, en_b, out_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000", {en_a, en_b, out_en});
      end
      checks++;
      if (pb_db !== 4'b0000) begin
         errors++;
         $display("FAIL reset_pb_db: got %b want 0000", pb_db);
      end
      checks++;
      if (rst_out_n !== 1'b0) begin
         errors++;
         $display("FAIL reset_rst_out_n: got %b want 0", rst_out_n);
      end
      tick();
      tick();
      rst = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         checks++;
         if (rst_out_n !== (e >= 3)) begin
            errors++;
            $display("FAIL reset_stretch e=%0d: got %b want %b", e, rst_out_n, (e >= 3));
         end
      end
   endtask

   task automatic test_clean_press();
      do_reset();
      pb = 4'b0001;
      for (int e = 0; e < 20; e++) begin
         tick();
         checks++;
         if ({en_a, en_b, out_en} !== {(e == 5), 2'b00}) begin
            errors++;
            $display("FAIL clean_strobes e=%0d: got %b want %b", e, {en_a, en_b, out_en}, {(e == 5), 2'b00});
         end
         checks++;
         if (pb_db !== ((e >= 5) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL clean_pb_db e=%0d: got %b", e, pb_db);
         end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] burst;
      do_reset();
      burst = 8'b0011_0011;
      for (int e = 0; e < 25; e++) begin
         pb = {2'b00, (e >= 8) ? 1'b1 : burst[e], 1'b0};
         tick();
         checks++;
         if (en_b !== (e == 13)) begin
            errors++;
            $display("FAIL bounce_en_b e=%0d: got %b want %b", e, en_b, (e == 13));
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      pb = 4'b0111;
      for (int e = 0; e < 10; e++) begin
         tick();
         checks++;
         if ({en_a, en_b, out_en} !== {3{(e == 5)}}) begin
            errors++;
            $display("FAIL simul_strobes e=%0d: got %b want %b", e, {en_a, en_b, out_en}, {3{(e == 5)}});
         end
      end
      checks++;
      if (pb_db !== 4'b0111) begin
         errors++;
         $display("FAIL simul_pb_db: got %b want 0111", pb_db);
      end
   endtask

   task automatic test_soft_reset();
      do_reset();
      pb = 4'b1001;
      for (int e = 0; e < 15; e++) begin
         tick();
         checks++;
         if (rst_out_n !== !(e >= 5 && e <= 8)) begin
            errors++;
            $display("FAIL softrst_rst_out_n e=%0d: got %b want %b", e, rst_out_n, !(e >= 5 && e <= 8));
         end
         checks++;
         if (en_a !== 1'b0) begin
            errors++;
            $display("FAIL softrst_en_a e=%0d: got %b want 0", e, en_a);
         end
      end
      checks++;
      if (pb_db !== 4'b1001) begin
         errors++;
         $display("FAIL softrst_pb_db: got %b want 1001", pb_db);
      end
   endtask

   task automatic test_stretch_reload();
      logic [8:0] pat;
      do_reset();
      // pb2[3]: high for samples 0-2, low 3-6, high from 7; second rise lands with rcnt=2.
      pat = 9'b1_1000_0111;
      for (int e = 0; e < 23; e++) begin
         pb2 = {(e >= 9) ? 1'b1 : pat[e], 3'b000};
         tick();
         checks++;
         if (rst_out_n2 !== !(e >= 3 && e <= 17)) begin
            errors++;
            $display("FAIL reload_rst_out_n e=%0d: got %b want %b", e, rst_out_n2, !(e >= 3 && e <= 17));
         end
      end
   endtask

   task automatic test_async_mid();
      do_reset();
      pb = 4'b0100;
      repeat (8) tick();
      pb = 4'b0101;
      repeat (4) tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (pb_db !== 4'b0000) begin
         errors++;
         $display("FAIL async_pb_db: got %b want 0000", pb_db);
      end
      checks++;
      if (rst_out_n !== 1'b0) begin
         errors++;
         $display("FAIL async_rst_out_n: got %b want 0", rst_out_n);
      end
      checks++;
      if ({en_a, en_b, out_en} !== 3'b000) begin
         errors++;
         $display("FAIL async_strobes: got %b want 000", {en_a, en_b, out_en});
      end
      tick();
      rst = 1'b1;
      for (int e = 0; e < 16; e++) begin
         tick();
         checks++;
         if ({en_a, out_en} !== {2{(e == 5)}}) begin
            errors++;
            $display("FAIL async_requal e=%0d: got %b want %b", e, {en_a, out_en}, {2{(e == 5)}});
         end
      end
      checks++;
      if (pb_db !== 4'b0101) begin
         errors++;
         $display("FAIL async_pb_db_after: got %b want 0101", pb_db);
      end
   endtask

   initial begin
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_soft_reset();
      test_stretch_reload();
      test_async_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
